// File: rtl/irrigation_matrix_scanner.sv
// irrigation_matrix_scanner: column-scanned LED matrix driver for irrigation status glyphs.
// in: clk, reset, enable, irrigation_status  out: col_sel, rows, frame_start, status_shown
module irrigation_matrix_scanner #(
  parameter int NUM_COLS = 5,
  parameter int NUM_ROWS = 7,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 25,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter logic [NUM_COLS*NUM_ROWS-1:0] GLYPH_0 = 35'h0_0000_0000,
  parameter logic [NUM_COLS*NUM_ROWS-1:0] GLYPH_1 = 35'h0_8102_0408,
  parameter logic [NUM_COLS*NUM_ROWS-1:0] GLYPH_2 = 35'h7_FFFF_FFFF,
  parameter logic [NUM_COLS*NUM_ROWS-1:0] GLYPH_3 = 35'h2_2A8A_2A22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          irrigation_status,
  output logic [NUM_COLS-1:0] col_sel,
  output logic [NUM_ROWS-1:0] rows,
  output logic                frame_start,
  output logic [1:0]          status_shown
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(NUM_COLS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int GW = NUM_COLS * NUM_ROWS;

  localparam logic [NUM_COLS-1:0] COL_IDLE =
    COL_ACTIVE_LOW ? {NUM_COLS{1'b1}} : {NUM_COLS{1'b0}};
  localparam logic [NUM_COLS-1:0] COL_ONE =
    {{(NUM_COLS-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pre_cnt, pre_d;
  logic [CW-1:0]     col_idx, col_d;
  logic [BW-1:0]     blink_cnt, bcnt_d;
  logic              blink_on, bon_d;
  logic [1:0]        status_q, status_d;

  logic [NUM_COLS-1:0] col_sel_d;
  logic [NUM_ROWS-1:0] rows_d;
  logic                fs_d;
  logic [1:0]          shown_d;

  logic [GW-1:0]       glyph;
  logic [NUM_ROWS-1:0] slice;
  logic                last_pre;
  logic                last_col;
  logic                blank;
  logic                dark;

  always_comb begin
    glyph = GLYPH_0;
    unique case (status_q)
      2'd0: glyph = GLYPH_0;
      2'd1: glyph = GLYPH_1;
      2'd2: glyph = GLYPH_2;
      2'd3: glyph = GLYPH_3;
    endcase
  end

  assign slice    = glyph[col_idx*NUM_ROWS +: NUM_ROWS];
  assign last_pre = (pre_cnt == PW'(SCAN_DIV - 1));
  assign last_col = (col_idx == CW'(NUM_COLS - 1));
  assign blank    = (pre_cnt < PW'(BLANK_CYCLES));
  // alarm glyph is suppressed during the off half of the blink
  assign dark     = (status_q == 2'd3) && !blink_on;

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_cnt;
    col_d     = col_idx;
    bcnt_d    = blink_cnt;
    bon_d     = blink_on;
    status_d  = status_q;
    col_sel_d = COL_IDLE;
    rows_d    = '0;
    fs_d      = 1'b0;
    shown_d   = status_q;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_SCAN;
          status_d = irrigation_status;
          pre_d    = '0;
        end
        S_SCAN: begin
          col_sel_d = COL_IDLE ^ (COL_ONE << col_idx);
          rows_d    = (blank || dark) ? '0 : slice;
          fs_d      = (pre_cnt == '0) && (col_idx == '0);
          pre_d     = pre_cnt + PW'(1);
          if (last_pre) begin
            pre_d = '0;
            col_d = col_idx + CW'(1);
            // frame boundary: only place status is re-sampled
            if (last_col) begin
              col_d    = '0;
              status_d = irrigation_status;
              bcnt_d   = blink_cnt + BW'(1);
              if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d = '0;
                bon_d  = ~blink_on;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pre_cnt      <= '0;
      col_idx      <= '0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
      status_q     <= 2'd0;
      col_sel      <= COL_IDLE;
      rows         <= '0;
      frame_start  <= 1'b0;
      status_shown <= 2'd0;
    end else begin
      state_q      <= state_d;
      pre_cnt      <= pre_d;
      col_idx      <= col_d;
      blink_cnt    <= bcnt_d;
      blink_on     <= bon_d;
      status_q     <= status_d;
      col_sel      <= col_sel_d;
      rows         <= rows_d;
      frame_start  <= fs_d;
      status_shown <= shown_d;
    end
  end

endmodule

// File: tb/tb_irrigation_matrix_scanner.sv
// tb_irrigation_matrix_scanner: directed bench with a frame-position model
// for a small override instance plus arithmetic checks on a default instance.
module tb_irrigation_matrix_scanner;

  localparam int NC = 3;
  localparam int NR = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    status = 2'd0;
  logic [NC-1:0] col_sel;
  logic [NR-1:0] rows;
  logic          fs;
  logic [1:0]    shown;

  logic          reset2 = 1'b1;
  logic          en2 = 1'b0;
  logic [1:0]    st2 = 2'd0;
  logic [4:0]    col_sel2;
  logic [6:0]    rows2;
  logic          fs2;
  logic [1:0]    shown2;

  int n_chk = 0;
  int n_fail = 0;

  irrigation_matrix_scanner #(
    .NUM_COLS(NC),
    .NUM_ROWS(NR),
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF),
    .COL_ACTIVE_LOW(1'b1),
    .GLYPH_0(12'h000),
    .GLYPH_1(12'hA5C),
    .GLYPH_2(12'hFFF),
    .GLYPH_3(12'hA22)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .irrigation_status(status),
    .col_sel(col_sel),
    .rows(rows),
    .frame_start(fs),
    .status_shown(shown)
  );

  irrigation_matrix_scanner u_def (
    .clk(clk),
    .reset(reset2),
    .enable(en2),
    .irrigation_status(st2),
    .col_sel(col_sel2),
    .rows(rows2),
    .frame_start(fs2),
    .status_shown(shown2)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] glyph(input logic [1:0] s);
    case (s)
      2'd0:    return 12'h000;
      2'd1:    return 12'hA5C;
      2'd2:    return 12'hFFF;
      default: return 12'hA22;
    endcase
  endfunction

  // model: position within the frame, frame count since reset,
  // and the status captured for the current frame
  bit            m_started = 1'b0;
  int            m_pos = 0;
  int            m_frame = 0;
  logic [1:0]    m_stat = 2'd0;
  logic [NC-1:0] e_col = 3'b111;
  logic [NR-1:0] e_rows = '0;
  logic          e_fs = 1'b0;
  logic [1:0]    e_shown = 2'd0;

  always @(posedge clk or posedge reset) begin
    int  slot;
    int  off;
    bit  lit;
    if (reset) begin
      m_started = 1'b0;
      m_pos = 0;
      m_frame = 0;
      m_stat = 2'd0;
      e_col = 3'b111;
      e_rows = '0;
      e_fs = 1'b0;
      e_shown = 2'd0;
    end else if (!enable) begin
      e_col = 3'b111;
      e_rows = '0;
      e_fs = 1'b0;
      e_shown = m_stat;
    end else if (!m_started) begin
      e_col = 3'b111;
      e_rows = '0;
      e_fs = 1'b0;
      e_shown = m_stat;
      m_stat = status;
      m_started = 1'b1;
      m_pos = 0;
    end else begin
      slot = m_pos / SD;
      off = m_pos % SD;
      lit = !(m_stat == 2'd3 && ((m_frame / BF) % 2) == 1);
      e_col = 3'b111 & ~(3'b001 << slot);
      e_rows = (off < BC || !lit) ? 4'h0
             : 4'(glyph(m_stat) >> (slot * NR));
      e_fs = (m_pos == 0);
      e_shown = m_stat;
      m_pos++;
      if (m_pos == SD * NC) begin
        m_pos = 0;
        m_frame++;
        m_stat = status;
      end
    end
  end

  always @(negedge clk) begin
    check("m_col", col_sel, e_col);
    check("m_rows", rows, e_rows);
    check("m_fs", fs, e_fs);
    check("m_shown", shown, e_shown);
  end

  logic [2:0] col_tab[3] = '{3'b110, 3'b101, 3'b011};
  logic [3:0] row_tab[3] = '{4'hC, 4'h5, 4'hA};
  bit         lit_tab[8] = '{1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst_col", col_sel, 3'b111);
    check("rst_rows", rows, 4'h0);
    check("rst_fs", fs, 1'b0);
    check("rst_shown", shown, 2'd0);
    reset = 1'b0;
    reset2 = 1'b0;

    // first frame at status 1
    @(negedge clk);
    enable = 1'b1;
    status = 2'd1;
    @(negedge clk);
    check("s1_start_fs", fs, 1'b0);
    check("s1_start_col", col_sel, 3'b111);
    for (int s = 0; s < 3; s++) begin
      for (int o = 0; o < 4; o++) begin
        @(negedge clk);
        check("s1_col", col_sel, col_tab[s]);
        check("s1_rows", rows, (o == 0) ? 4'h0 : row_tab[s]);
        check("s1_fs", fs, (s == 0 && o == 0));
      end
    end

    // status change mid-column-1 waits for the frame boundary
    repeat (6) @(negedge clk);
    status = 2'd2;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (fs) seen = 1;
      else check("s2_hold", shown, 2'd1);
    end
    check("s2_fs_seen", seen, 1);
    check("s2_shown", shown, 2'd2);
    @(negedge clk);
    check("s2_rows", rows, 4'hF);

    // enable gap with column 2 at pre_cnt 2
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (fs) seen = 1;
    end
    check("s4_fs_seen", seen, 1);
    repeat (9) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("s4_gap_col", col_sel, 3'b111);
      check("s4_gap_rows", rows, 4'h0);
      check("s4_gap_fs", fs, 1'b0);
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s4_resume_col", col_sel, 3'b011);
      check("s4_resume_rows", rows, 4'hF);
      check("s4_resume_fs", fs, 1'b0);
    end
    @(negedge clk);
    check("s4_next_fs", fs, 1'b1);
    check("s4_next_col", col_sel, 3'b110);

    // alarm status, then asynchronous reset mid-frame
    status = 2'd3;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("s5_async_col", col_sel, 3'b111);
    check("s5_async_rows", rows, 4'h0);
    check("s5_async_fs", fs, 1'b0);
    check("s5_async_shown", shown, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s5_start_fs", fs, 1'b0);
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (c == 0) check("s3_fs", fs, 1'b1);
        if (c == 1) begin
          check("s3_col", col_sel, 3'b110);
          check("s3_rows0", rows, lit_tab[f] ? 4'h2 : 4'h0);
        end
        if (c == 9) begin
          check("s3_col2", col_sel, 3'b011);
          check("s3_rows2", rows, lit_tab[f] ? 4'hA : 4'h0);
        end
      end
    end

    // default parameters, status 2 for 10 frames
    en2 = 1'b1;
    st2 = 2'd2;
    @(negedge clk);
    check("d_start_fs", fs2, 1'b0);
    check("d_start_col", col_sel2, 5'b11111);
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 5; c++) begin
        for (int o = 0; o < 1000; o++) begin
          @(negedge clk);
          check("d_col", col_sel2, 5'b11111 ^ (5'b00001 << c));
          check("d_rows", rows2, (o >= 50) ? 7'h7F : 7'h00);
          check("d_fs", fs2, (c == 0 && o == 0));
          if (c == 0 && o == 0) check("d_shown", shown2, 2'd2);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
